// File: rtl/reg_file_2r1w_if.sv
// rtl/reg_file_2r1w_if.sv - write/read bus of the 2-read 1-write register file
// The master drives the write port and read addresses; the register file returns read data and the valid count.
interface reg_file_2r1w_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
);
  logic              enWr;
  logic [ADDR_W-1:0] addrWr;
  logic [WIDTH-1:0]  dataWr;
  logic [ADDR_W-1:0] addrRd0;
  logic [WIDTH-1:0]  dataRd0;
  logic              validRd0;
  logic [ADDR_W-1:0] addrRd1;
  logic [WIDTH-1:0]  dataRd1;
  logic              validRd1;
  logic [ADDR_W:0]   wrCount;

  modport master (
    output enWr, addrWr, dataWr, addrRd0, addrRd1,
    input  dataRd0, validRd0, dataRd1, validRd1, wrCount
  );

  modport slave (
    input  enWr, addrWr, dataWr, addrRd0, addrRd1,
    output dataRd0, validRd0, dataRd1, validRd1, wrCount
  );
endinterface

// File: rtl/reg_file_2r1w.sv
// rtl/reg_file_2r1w.sv - 2**ADDR_W x WIDTH register file, one sync write port, two combinational read ports
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a read port addressing the written entry.
module reg_file_2r1w #(
  parameter int WIDTH   = 8,
  parameter int ADDR_W  = 3,
  parameter int ZERO_R0 = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_file_2r1w_if.slave       bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] L_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] L_RST_COUNT = (ZERO_R0 != 0) ? (ADDR_W + 1)'(1) : '0;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [ADDR_W:0]  r_count;

  logic w_wr_ok;
  logic w_byp0;
  logic w_byp1;

  // Entry 0 stays zero and valid from reset onward when hardwired, so writes to it are simply dropped.
  assign w_wr_ok = bus.enWr && !((ZERO_R0 != 0) && (bus.addrWr == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_vld    <= '0;
      r_vld[0] <= (ZERO_R0 != 0);
      r_count  <= L_RST_COUNT;
    end else if (w_wr_ok) begin
      r_mem[bus.addrWr] <= bus.dataWr;
      r_vld[bus.addrWr] <= 1'b1;
      if (!r_vld[bus.addrWr] && (r_count != L_FULL)) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign w_byp0 = w_wr_ok && !rst && (bus.addrRd0 == bus.addrWr);
  assign w_byp1 = w_wr_ok && !rst && (bus.addrRd1 == bus.addrWr);
`else
  assign w_byp0 = 1'b0;
  assign w_byp1 = 1'b0;
`endif

  assign bus.dataRd0  = w_byp0 ? bus.dataWr : r_mem[bus.addrRd0];
  assign bus.validRd0 = w_byp0 | r_vld[bus.addrRd0];
  assign bus.dataRd1  = w_byp1 ? bus.dataWr : r_mem[bus.addrRd1];
  assign bus.validRd1 = w_byp1 | r_vld[bus.addrRd1];
  assign bus.wrCount  = r_count;
endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb/tb_reg_file_2r1w.sv - self-checking bench for reg_file_2r1w, plain and ZERO_R0 instances
// Both instances see identical stimulus; each is compared against its own array model.
module tb_reg_file_2r1w;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  logic [7:0] m_mem [2][8];
  bit         m_vld [2][8];

  reg_file_2r1w_if #(.WIDTH(8), .ADDR_W(3)) if0 ();
  reg_file_2r1w_if #(.WIDTH(8), .ADDR_W(3)) if1 ();

  reg_file_2r1w #(.WIDTH(8), .ADDR_W(3), .ZERO_R0(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  reg_file_2r1w #(.WIDTH(8), .ADDR_W(3), .ZERO_R0(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mdl_count(input int z);
    int c = 0;
    for (int i = 0; i < 8; i++) c += m_vld[z][i] ? 1 : 0;
    return c;
  endfunction

  function automatic void mdl_reset();
    for (int z = 0; z < 2; z++)
      for (int i = 0; i < 8; i++) begin
        m_mem[z][i] = 8'h00;
        m_vld[z][i] = (z == 1 && i == 0);
      end
  endfunction

  // Expected read result during the current cycle, given the inputs being presented.
  function automatic logic [8:0] mdl_read(input int z, input logic r, input logic e,
                                          input logic [2:0] aw, input logic [7:0] dw,
                                          input logic [2:0] ar);
    if (z == 1 && ar == 3'd0) return {1'b1, 8'h00};
`ifdef REGFILE_BYPASS_EN
    if (e && !r && ar == aw) return {1'b1, dw};
`endif
    return {m_vld[z][ar], m_mem[z][ar]};
  endfunction

  task automatic cycle(input logic r, input logic e, input logic [2:0] aw, input logic [7:0] dw,
                       input logic [2:0] a0, input logic [2:0] a1);
    logic [8:0] x0, x1;
    @(negedge clk);
    rst = r;
    if0.enWr = e; if0.addrWr = aw; if0.dataWr = dw; if0.addrRd0 = a0; if0.addrRd1 = a1;
    if1.enWr = e; if1.addrWr = aw; if1.dataWr = dw; if1.addrRd0 = a0; if1.addrRd1 = a1;
    #2;
    for (int z = 0; z < 2; z++) begin
      x0 = mdl_read(z, r, e, aw, dw, a0);
      x1 = mdl_read(z, r, e, aw, dw, a1);
      if (z == 0) begin
        check("d0_rd0", {24'd0, if0.dataRd0}, {24'd0, x0[7:0]});
        check("d0_vld0", {31'd0, if0.validRd0}, {31'd0, x0[8]});
        check("d0_rd1", {24'd0, if0.dataRd1}, {24'd0, x1[7:0]});
        check("d0_vld1", {31'd0, if0.validRd1}, {31'd0, x1[8]});
        check("d0_cnt", {28'd0, if0.wrCount}, 32'(mdl_count(0)));
      end else begin
        check("d1_rd0", {24'd0, if1.dataRd0}, {24'd0, x0[7:0]});
        check("d1_vld0", {31'd0, if1.validRd0}, {31'd0, x0[8]});
        check("d1_rd1", {24'd0, if1.dataRd1}, {24'd0, x1[7:0]});
        check("d1_vld1", {31'd0, if1.validRd1}, {31'd0, x1[8]});
        check("d1_cnt", {28'd0, if1.wrCount}, 32'(mdl_count(1)));
      end
    end
    // Commit what the coming rising edge will do.
    if (r) mdl_reset();
    else if (e) begin
      for (int z = 0; z < 2; z++) begin
        if (!(z == 1 && aw == 3'd0)) begin
          m_mem[z][aw] = dw;
          m_vld[z][aw] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    if0.enWr = 1'b0; if0.addrWr = '0; if0.dataWr = '0; if0.addrRd0 = '0; if0.addrRd1 = '0;
    if1.enWr = 1'b0; if1.addrWr = '0; if1.dataWr = '0; if1.addrRd0 = '0; if1.addrRd1 = '0;
    repeat (2) @(posedge clk);
    mdl_reset();

    // Reset clears a preloaded entry
    cycle(0, 1, 3'd3, 8'h5A, 3'd3, 3'd3);
    cycle(1, 0, 3'd0, 8'h00, 3'd3, 3'd3);
    cycle(0, 0, 3'd0, 8'h00, 3'd3, 3'd3);
    check("rst_data", {24'd0, if0.dataRd0}, 32'h00);
    check("rst_valid", {31'd0, if0.validRd0}, 32'd0);
    check("rst_cnt", {28'd0, if0.wrCount}, 32'd0);
    check("rst_cnt_z", {28'd0, if1.wrCount}, 32'd1);

    // Disabled write leaves entry untouched
    cycle(0, 0, 3'd2, 8'hA5, 3'd2, 3'd2);
    cycle(0, 0, 3'd0, 8'h00, 3'd2, 3'd2);
    check("noen_data", {24'd0, if0.dataRd0}, 32'h00);
    check("noen_valid", {31'd0, if0.validRd0}, 32'd0);

    // Basic write then read on both ports
    cycle(0, 1, 3'd2, 8'hA5, 3'd0, 3'd0);
    cycle(0, 0, 3'd0, 8'h00, 3'd2, 3'd2);
    check("wr_rd0", {24'd0, if0.dataRd0}, 32'hA5);
    check("wr_rd1", {24'd0, if0.dataRd1}, 32'hA5);
    check("wr_cnt", {28'd0, if0.wrCount}, 32'd1);

    // Overwrite keeps the count
    cycle(1, 0, 3'd0, 8'h00, 3'd0, 3'd0);
    cycle(0, 1, 3'd4, 8'h11, 3'd0, 3'd0);
    cycle(0, 1, 3'd4, 8'h22, 3'd0, 3'd0);
    cycle(0, 0, 3'd0, 8'h00, 3'd0, 3'd4);
    check("ovw_rd1", {24'd0, if0.dataRd1}, 32'h22);
    check("ovw_cnt", {28'd0, if0.wrCount}, 32'd1);

    // Fill every entry, then saturate
    for (int i = 0; i < 8; i++) cycle(0, 1, 3'(i), 8'(8'h30 + i), 3'd0, 3'd0);
    cycle(0, 0, 3'd0, 8'h00, 3'd7, 3'd1);
    check("full_cnt", {28'd0, if0.wrCount}, 32'd8);
    check("full_cnt_z", {28'd0, if1.wrCount}, 32'd8);
    cycle(0, 1, 3'd6, 8'h99, 3'd0, 3'd0);
    cycle(0, 0, 3'd0, 8'h00, 3'd6, 3'd6);
    check("sat_cnt", {28'd0, if0.wrCount}, 32'd8);

    // Same-cycle read of the address being written
    cycle(1, 0, 3'd0, 8'h00, 3'd0, 3'd0);
    cycle(0, 1, 3'd5, 8'h3C, 3'd5, 3'd0);
`ifdef REGFILE_BYPASS_EN
    check("same_cyc", {24'd0, if0.dataRd0}, 32'h3C);
`else
    check("same_cyc", {24'd0, if0.dataRd0}, 32'h00);
`endif
    cycle(0, 0, 3'd0, 8'h00, 3'd5, 3'd0);
    check("after_edge", {24'd0, if0.dataRd0}, 32'h3C);

    // Hardwired entry 0 ignores writes and never forwards
    cycle(0, 1, 3'd0, 8'hFF, 3'd0, 3'd0);
    check("z0_data", {24'd0, if1.dataRd0}, 32'h00);
    check("z0_valid", {31'd0, if1.validRd0}, 32'd1);
    cycle(0, 0, 3'd0, 8'h00, 3'd0, 3'd0);
    check("z0_after", {24'd0, if1.dataRd0}, 32'h00);
    check("z0_cnt", {28'd0, if1.wrCount}, 32'd2);

    // Reset wins over a simultaneous write
    cycle(1, 1, 3'd1, 8'h77, 3'd1, 3'd1);
    cycle(0, 0, 3'd0, 8'h00, 3'd1, 3'd1);
    check("coll_data", {24'd0, if0.dataRd0}, 32'h00);
    check("coll_valid", {31'd0, if0.validRd0}, 32'd0);
    check("coll_cnt", {28'd0, if0.wrCount}, 32'd0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), 3'($urandom),
            8'($urandom), 3'($urandom), 3'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Parametrised successor to the single enabled datapath register: a bank of 2**ADDR_W registers of WIDTH bits each.
- One synchronous write port and two combinational read ports.
- Per-entry valid bits.
- Sits between the ALU result bus and the operand muxes of the CPU datapath, replacing discrete enabled registers.

Parameters:
- WIDTH, 8, data width of each entry in bits.
- ADDR_W, 3, address width; depth = 2**ADDR_W entries (default 8).
- ZERO_R0, 0, when 1, entry 0 is hardwired to zero, is never written, and always reads valid.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous reset, active-high.
- enWr  input  1  write enable; write is committed on the rising edge of clk when high.
- addrWr  input  ADDR_W  write address.
- dataWr  input  WIDTH  write data.
- addrRd0  input  ADDR_W  read port 0 address.
- dataRd0  output  WIDTH  read port 0 data (combinational).
- validRd0  output  1  entry addressed by port 0 has been written since reset.
- addrRd1  input  ADDR_W  read port 1 address.
- dataRd1  output  WIDTH  read port 1 data (combinational).
- validRd1  output  1  entry addressed by port 1 has been written since reset.
- wrCount  output  ADDR_W+1  number of valid entries, 0..2**ADDR_W.

Behaviour:
- Storage:
  - Array mem[0 .. 2**ADDR_W-1] of WIDTH bits.
  - Vector vld[0 .. 2**ADDR_W-1].
  - Counter wrCount.
- Reset (rst high at a rising clk edge):
  - All mem entries become 0, all vld bits become 0, wrCount becomes 0.
  - If ZERO_R0=1, vld[0] reads as 1 and wrCount counts entry 0, so wrCount=1 after reset.
  - rst overrides enWr in the same cycle; a write presented during reset is discarded.
  - Reset mid-operation clears everything at that edge with no partial state.
- Write, when rst=0 and enWr=1 at a rising edge:
  - mem[addrWr] <= dataWr and vld[addrWr] <= 1.
  - If vld[addrWr] was 0 beforehand, wrCount increments by 1; overwriting a valid entry leaves wrCount unchanged.
  - wrCount saturates at 2**ADDR_W, which is reachable and never wraps.
  - When enWr=0, all entries hold their value, matching the hold-mux semantics of the existing enabled register.
- ZERO_R0=1:
  - A write to address 0 is ignored: mem[0], vld[0] and wrCount are unchanged.
  - Reads of address 0 return 0 with valid=1.
- Read:
  - dataRdN = mem[addrRdN] and validRdN = vld[addrRdN], purely combinational, zero cycles of latency from the address.
  - A write becomes visible on the read ports the cycle after the edge that commits it (write-then-read), unless the bypass feature is compiled in.
- Simultaneous events:
  - Both read ports may address the same entry; both return identical data.
  - A read of the address being written in the same cycle returns the old value and old valid, unless the bypass feature is compiled in.
- Widths: all addresses cover the full range, so out-of-range addressing is impossible. No X may propagate from unwritten entries, because reset zeroes them.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - When enWr=1, rst=0 and addrRdN == addrWr, dataRdN = dataWr and validRdN = 1 combinationally in the same cycle.
  - Under ZERO_R0=1, the bypass is suppressed for address 0.
  - The bypass does not affect wrCount timing.
- Undefined:
  - No forwarding logic exists; a same-cycle read returns the pre-write contents.

Test Plan:
- Reset: preload mem[3]=0x5A, then assert rst for 1 cycle -> dataRd0 at addrRd0=3 reads 0x00, validRd0=0, wrCount=0. With ZERO_R0=1, wrCount=1.
- Basic write/read: enWr=1, addrWr=2, dataWr=0xA5, one edge -> next cycle, with addrRd0=2 and addrRd1=2, both ports read 0xA5 with valid=1 and wrCount=1. Same write with enWr=0 -> entry stays 0x00 and valid stays 0.
- Overwrite and count: write 0x11 to addr 4, then 0x22 to addr 4 -> dataRd1=0x22, wrCount=1. Then write all 8 addresses -> wrCount=8, and a further write keeps wrCount at 8.
- Same-cycle read of the write address (addrWr=5, dataWr=0x3C, addrRd0=5, old value 0x00):
  - Without REGFILE_BYPASS_EN -> dataRd0=0x00 during the cycle and 0x3C after the edge.
  - With REGFILE_BYPASS_EN -> dataRd0=0x3C during the cycle.
- ZERO_R0=1: write 0xFF to addr 0 -> dataRd0=0x00, validRd0=1, wrCount unchanged, and no bypass of 0xFF.
- Reset collision: rst=1 and enWr=1 with addrWr=1, dataWr=0x77 in the same cycle -> after the edge, entry 1 reads 0x00, valid=0, wrCount=0.
